// File: rtl/serial_byte_tx.sv
// UART-style 8N1/8N2 byte transmitter, LSB first, with a registered ready for producer pacing.
// Optional clear-to-send gating of ready is enabled by defining SERIAL_TX_CTS_EN.
module serial_byte_tx #(
  parameter int CLK_DIVIDER = 868,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_available,
  output logic       ready,
  input  logic       cts,
  output logic       tx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIVIDER - 1);
  localparam logic        STOP_RELOAD = 1'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        cts_ok;
  logic        baud_tick;

`ifdef SERIAL_TX_CTS_EN
  assign cts_ok = cts;
`else
  logic unused_cts;
  assign cts_ok     = 1'b1;
  assign unused_cts = cts;
`endif

  assign baud_tick = (baud_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = cts_ok;
        if (ready_q && data_available) begin
          shift_d = data;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          baud_d  = BAUD_RELOAD;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_d    = BAUD_RELOAD;
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = STOP_RELOAD;
            state_d    = STOP;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q) begin
            baud_d     = BAUD_RELOAD;
            stop_cnt_d = 1'b0;
          end else begin
            // Line stays high; ready returns only if the receiver allows it.
            baud_d  = 16'd0;
            state_d = IDLE;
            ready_d = cts_ok;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx: frame vector table plus reset-abort and clear-to-send sequences.
// Builds with or without SERIAL_TX_CTS_EN; the stop-bit count follows the macro.
module tb_serial_byte_tx;

  localparam int DIV = 4;
`ifdef SERIAL_TX_CTS_EN
  localparam int STOPB = 2;
`else
  localparam int STOPB = 1;
`endif
  localparam int FRAME = (9 + STOPB) * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       data_available;
  logic       ready;
  logic       cts;
  logic       tx;

  int n_vec = 0;
  int n_err = 0;

  serial_byte_tx #(.CLK_DIVIDER(DIV), .STOP_BITS(STOPB)) dut (
    .clk            (clk),
    .reset          (reset),
    .data           (data),
    .data_available (data_available),
    .ready          (ready),
    .cts            (cts),
    .tx             (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] byte_in;
    logic [9:0] exp_bits; // [0]=start, [8:1]=data LSB first, [9]=stop
    bit         inject_ff;
  } frame_vec_t;

  frame_vec_t vecs[5];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for ready, strobes one byte and checks every cycle of the frame.
  task automatic run_frame(input logic [7:0] b, input logic [9:0] exp_bits,
                           input bit inject_ff, input int cts_drop_k,
                           input logic exp_end_ready);
    int w = 0;
    int idx;
    logic exp_tx;
    @(negedge clk);
    while (ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      check("ready_wait_timeout", ready, 1'b1);
      return;
    end
    data = b;
    data_available = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        data_available = 1'b0;
        data = 8'($urandom_range(0, 255));
      end
      if (k < FRAME) begin
        idx = k / DIV;
        exp_tx = (idx < 10) ? exp_bits[idx] : 1'b1;
        check($sformatf("tx_b%02h_k%0d", b, k), tx, exp_tx);
        check($sformatf("ready_low_b%02h_k%0d", b, k), ready, 1'b0);
      end else begin
        check($sformatf("tx_end_b%02h", b), tx, 1'b1);
        check($sformatf("ready_end_b%02h", b), ready, exp_end_ready);
      end
      if (inject_ff && k == 17) begin
        data = 8'hFF;
        data_available = 1'b1;
      end
      if (inject_ff && k == 18) data_available = 1'b0;
      if (k == cts_drop_k) cts = 1'b0;
    end
  endtask

  initial begin
    logic [9:0] abort_bits;
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA3, 10'h346, 1'b0};
    vecs[2] = '{8'h0D, 10'h21A, 1'b0};
    vecs[3] = '{8'h3C, 10'h278, 1'b1};
    vecs[4] = '{8'h00, 10'h200, 1'b0};

    // Reset for 3 cycles, then ready rises on the first edge after release.
    reset = 1'b1;
    data = 8'h00;
    data_available = 1'b0;
    cts = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_tx", tx, 1'b1);
      check("reset_ready", ready, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_ready", ready, 1'b1);
    check("post_reset_tx", tx, 1'b1);

    // Contiguous frames from the table; vector 3 has a stray 0xFF strobe mid-frame.
    foreach (vecs[i])
      run_frame(vecs[i].byte_in, vecs[i].exp_bits, vecs[i].inject_ff, -1, 1'b1);

    // No spurious frame from the dropped strobe.
    repeat (8) begin
      @(posedge clk);
      #1;
      check("idle_tx", tx, 1'b1);
      check("idle_ready", ready, 1'b1);
    end

    // Reset asserted at cycle 17 of a 0x55 frame.
    abort_bits = 10'h2AA;
    @(negedge clk);
    data = 8'h55;
    data_available = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) data_available = 1'b0;
      check($sformatf("abort_tx_k%0d", k), tx, abort_bits[k / DIV]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_reset_tx", tx, 1'b1);
    check("abort_reset_ready", ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_release_ready", ready, 1'b1);
    check("abort_release_tx", tx, 1'b1);
    run_frame(8'h41, 10'h282, 1'b0, -1, 1'b1);

`ifdef SERIAL_TX_CTS_EN
    // cts low holds ready low and strobes start nothing.
    @(negedge clk);
    cts = 1'b0;
    @(posedge clk);
    #1;
    check("cts_low_ready", ready, 1'b0);
    repeat (6) begin
      @(negedge clk);
      data = 8'hEE;
      data_available = 1'b1;
      @(posedge clk);
      #1;
      check("cts_low_hold_ready", ready, 1'b0);
      check("cts_low_hold_tx", tx, 1'b1);
    end
    data_available = 1'b0;
    @(negedge clk);
    cts = 1'b1;
    @(posedge clk);
    #1;
    check("cts_high_ready", ready, 1'b1);
    // cts drops mid-frame: frame completes, ready stays low afterwards.
    run_frame(8'h00, 10'h200, 1'b0, 10, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("cts_after_frame_ready", ready, 1'b0);
      check("cts_after_frame_tx", tx, 1'b1);
    end
    @(negedge clk);
    cts = 1'b1;
    @(posedge clk);
    #1;
    check("cts_restore_ready", ready, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
